// File: rtl/image_uart_sender_pkg.sv
// Shared types and constants for the program-image UART sender.
package image_sender_pkg;

  typedef enum logic [3:0] {
    IDLE,
    WAIT_L,
    LEN_LO,
    LEN_HI,
    WAIT_A,
    WAIT_EQ,
    DAT_LO,
    DAT_HI,
    WAIT_R
  } state_t;

  localparam logic [7:0] ASC_L  = 8'h4C;
  localparam logic [7:0] ASC_A  = 8'h41;
  localparam logic [7:0] ASC_EQ = 8'h3D;
  localparam logic [7:0] ASC_R  = 8'h52;

  localparam int unsigned TIMER_W = 24;

  function automatic logic is_wait(input state_t s);
    return s inside {WAIT_L, WAIT_A, WAIT_EQ, WAIT_R};
  endfunction

endpackage

// File: rtl/image_uart_sender_if.sv
// ROM read port plus UART byte TX/RX handshakes between sender and board logic.
interface image_uart_sender_if;
  logic [15:0] rom_addr;
  logic [15:0] rom_data;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic [7:0]  rx_data;
  logic        rx_valid;

  modport master (
    output rom_addr, tx_data, tx_valid,
    input  rom_data, tx_ready, rx_data, rx_valid
  );

  modport slave (
    input  rom_addr, tx_data, tx_valid,
    output rom_data, tx_ready, rx_data, rx_valid
  );
endinterface

// File: rtl/image_uart_sender_wait_timer.sv
// Loadable down-counter; expired is high whenever the count sits at zero.
module wait_timer
  import image_sender_pkg::*;
#(
  parameter int unsigned W = TIMER_W
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clear,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic         expired
);

  logic [W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (dec && cnt != '0) begin
      cnt <= cnt - W'(1);
    end
  end

  assign expired = (cnt == '0);

endmodule

// File: rtl/image_uart_sender.sv
// Streams length + 16-bit LE words from a ROM to a UART TX, paced by echoed prompts.
// IMAGE_SENDER_HANDSHAKE_EN selects prompt pacing with timeout; otherwise fixed gaps.
module image_uart_sender
  import image_sender_pkg::*;
#(
  parameter logic [23:0] TIMEOUT_CYCLES = 24'd12_000_000,
  parameter logic [15:0] GAP_CYCLES     = 16'd2000
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       start,
  input  logic [15:0]                length,
  image_uart_sender_if.master        bus,
  output logic                       busy,
  output logic                       done,
  output logic                       err
);

`ifdef IMAGE_SENDER_HANDSHAKE_EN
  localparam bit HS_EN = 1'b1;
`else
  localparam bit HS_EN = 1'b0;
`endif

  state_t               state, state_n;
  logic [15:0]          len_q;
  logic [7:0]           hi_q;
  logic                 accept, last_word;
  logic                 fin, abort;
  logic                 tmr_load, tmr_clear, tmr_dec, tmr_expired;
  logic [TIMER_W-1:0]   tmr_val;

  assign accept    = bus.tx_valid && bus.tx_ready;
  assign last_word = (bus.rom_addr == len_q - 16'd1);
  assign busy      = (state != IDLE);

  always_comb begin
    state_n      = state;
    bus.tx_valid = 1'b0;
    bus.tx_data  = '0;
    fin          = 1'b0;
    abort        = 1'b0;
    case (state)
      IDLE: if (start && length != '0) state_n = HS_EN ? WAIT_L : LEN_LO;
      WAIT_L: if (bus.rx_valid && bus.rx_data == ASC_L) state_n = LEN_LO;
      LEN_LO: begin
        bus.tx_valid = 1'b1;
        bus.tx_data  = len_q[7:0];
        if (bus.tx_ready) state_n = LEN_HI;
      end
      LEN_HI: begin
        bus.tx_valid = 1'b1;
        bus.tx_data  = len_q[15:8];
        if (bus.tx_ready) state_n = WAIT_A;
      end
      WAIT_A: begin
        if (HS_EN) begin
          if (bus.rx_valid && bus.rx_data == ASC_A) state_n = WAIT_EQ;
        end else if (tmr_expired) begin
          state_n = DAT_LO;
        end
      end
      WAIT_EQ: if (bus.rx_valid && bus.rx_data == ASC_EQ) state_n = DAT_LO;
      DAT_LO: begin
        bus.tx_valid = 1'b1;
        bus.tx_data  = bus.rom_data[7:0];
        if (bus.tx_ready) state_n = DAT_HI;
      end
      DAT_HI: begin
        bus.tx_valid = 1'b1;
        bus.tx_data  = hi_q;
        if (bus.tx_ready) begin
          if (!last_word)  state_n = WAIT_A;
          else if (HS_EN)  state_n = WAIT_R;
          else begin
            state_n = IDLE;
            fin     = 1'b1;
          end
        end
      end
      WAIT_R: begin
        if (bus.rx_valid && bus.rx_data == ASC_R) begin
          state_n = IDLE;
          fin     = 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase

    // A prompt seen on the expiry cycle still wins; only a stalled wait aborts.
    if (HS_EN && is_wait(state) && state_n == state && tmr_expired) begin
      state_n = IDLE;
      abort   = 1'b1;
    end

    tmr_load  = (state_n != state) && is_wait(state_n);
    tmr_clear = (state_n == IDLE);
    tmr_dec   = is_wait(state);
    tmr_val   = HS_EN ? TIMEOUT_CYCLES : {8'd0, GAP_CYCLES};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      len_q        <= '0;
      hi_q         <= '0;
      bus.rom_addr <= '0;
      done         <= 1'b0;
      err          <= 1'b0;
    end else begin
      state <= state_n;
      done  <= fin;
      if (state == IDLE && start) begin
        if (length == '0) begin
          err <= 1'b1;
        end else begin
          err          <= 1'b0;
          len_q        <= length;
          bus.rom_addr <= '0;
        end
      end
      if (abort) err <= 1'b1;
      if (state == DAT_LO && accept) hi_q <= bus.rom_data[15:8];
      if (state == DAT_HI && accept && !last_word) bus.rom_addr <= bus.rom_addr + 16'd1;
    end
  end

  wait_timer #(.W(TIMER_W)) u_timer (
    .clk      (clk),
    .reset    (reset),
    .clear    (tmr_clear),
    .load     (tmr_load),
    .load_val (tmr_val),
    .dec      (tmr_dec),
    .expired  (tmr_expired)
  );

endmodule

// File: tb/tb_image_uart_sender.sv
// Scoreboard bench for image_uart_sender: expected byte stream queued at start, monitor pops on accept.
module tb_image_uart_sender;

  localparam int GAP = 10;
`ifdef IMAGE_SENDER_HANDSHAKE_EN
  localparam bit HS = 1'b1;
`else
  localparam bit HS = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset, start;
  logic [15:0] length;
  logic        busy, done, err;

  image_uart_sender_if bus();

  image_uart_sender #(.TIMEOUT_CYCLES(24'd100), .GAP_CYCLES(16'd10)) dut (
    .clk    (clk),
    .reset  (reset),
    .start  (start),
    .length (length),
    .bus    (bus.master),
    .busy   (busy),
    .done   (done),
    .err    (err)
  );

  always #5 clk = ~clk;

  typedef struct { logic [7:0] val; bit gap; bit last; } exp_t;
  exp_t        exp_q[$];
  exp_t        e;
  logic [15:0] rom [256];
  assign bus.rom_data = rom[bus.rom_addr[7:0]];

  int          checks = 0, failures = 0;
  int          accept_cnt = 0, idle_cnt = 0, credits = 0;
  bit          credit_mode = 1'b0, done_due = 1'b0, hold_v = 1'b0;
  logic [7:0]  hold_d = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h, want %0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Random backpressure, or a fixed number of grants when credit_mode is set.
  initial begin
    bus.tx_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      bus.tx_ready = credit_mode ? (credits > 0) : ($urandom_range(0, 3) != 0);
    end
  end

  always @(negedge clk) begin
    if (reset) begin
      hold_v   = 1'b0;
      idle_cnt = 0;
      done_due = 1'b0;
    end else begin
      if (done || done_due) begin
        check("done_pulse", done, done_due);
        if (done) begin
          check("busy_at_done", busy, 0);
          check("err_at_done", err, 0);
        end
      end
      done_due = 1'b0;
      if (hold_v) begin
        check("stall_valid", bus.tx_valid, 1);
        check("stall_data", bus.tx_data, hold_d);
      end
      if (bus.tx_valid && bus.tx_ready) begin
        accept_cnt++;
        if (credit_mode && credits > 0) credits--;
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL tx_unexpected: got %0h, want no byte", bus.tx_data);
        end else begin
          e = exp_q.pop_front();
          check("tx_byte", bus.tx_data, e.val);
          if (e.gap) check("gap_idle", (idle_cnt >= GAP) ? 1 : 0, 1);
`ifndef IMAGE_SENDER_HANDSHAKE_EN
          if (e.last) done_due = 1'b1;
`endif
        end
        idle_cnt = 0;
        hold_v   = 1'b0;
      end else begin
        if (!bus.tx_valid) idle_cnt++;
        hold_v = bus.tx_valid;
        hold_d = bus.tx_data;
      end
`ifdef IMAGE_SENDER_HANDSHAKE_EN
      if (bus.rx_valid && bus.rx_data == 8'h52 && busy) done_due = 1'b1;
`endif
    end
  end

  task automatic send_rx(input logic [7:0] b);
    bus.rx_valid = 1'b1;
    bus.rx_data  = b;
    tick(1);
    bus.rx_valid = 1'b0;
    tick(2);
  endtask

  task automatic wait_bytes(input int target);
    int n = 0;
    while (accept_cnt < target && n < 3000) begin
      tick(1);
      n++;
    end
    check("wait_bytes", (accept_cnt >= target) ? 1 : 0, 1);
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy && n < 5000) begin
      tick(1);
      n++;
    end
    check("wait_idle", busy, 0);
  endtask

  task automatic do_start(input logic [15:0] n);
    start  = 1'b1;
    length = n;
    tick(1);
    start  = 1'b0;
  endtask

  task automatic push_expected(input int n);
    logic [15:0] l16;
    l16 = 16'(n);
    exp_q.push_back('{val: l16[7:0],  gap: 1'b0, last: 1'b0});
    exp_q.push_back('{val: l16[15:8], gap: 1'b0, last: 1'b0});
    for (int i = 0; i < n; i++) begin
      exp_q.push_back('{val: rom[i][7:0],  gap: !HS, last: 1'b0});
      exp_q.push_back('{val: rom[i][15:8], gap: 1'b0, last: (i == n - 1)});
    end
  endtask

  task automatic stall_phase(input int base);
    wait_bytes(base + 3);
    tick(50);
    check("stall_hold_valid", bus.tx_valid, 1);
    credit_mode = 1'b0;
  endtask

  task automatic run_transfer(input int n, input bit stall, input bit strays);
    int base;
    base = accept_cnt;
    push_expected(n);
    if (stall) begin
      credit_mode = 1'b1;
      credits     = 3;
    end
    do_start(16'(n));
    check("busy_after_start", busy, 1);
    check("err_after_start", err, 0);
`ifdef IMAGE_SENDER_HANDSHAKE_EN
    tick(3);
    send_rx(8'h4C);
    wait_bytes(base + 2);
    for (int w = 0; w < n; w++) begin
      tick(2);
      if (strays) begin
        send_rx(8'h20);
        send_rx(8'h0D);
      end
      send_rx(8'h41);
      for (int d = 0; d < 4; d++) send_rx(8'h30);
      check("no_early_word", accept_cnt, base + 2 + 2 * w);
      send_rx(8'h3D);
      if (stall && w == 0) stall_phase(base);
      wait_bytes(base + 4 + 2 * w);
      tick(2);
      send_rx(8'h3D);
    end
    tick(2);
    send_rx(8'h52);
`else
    if (stall) stall_phase(base);
`endif
    wait_idle();
    tick(2);
    check("queue_drained", exp_q.size(), 0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_rom_addr"}, bus.rom_addr, 0);
    check({tag, "_tx_data"},  bus.tx_data, 0);
    check({tag, "_tx_valid"}, bus.tx_valid, 0);
    check({tag, "_busy"},     busy, 0);
    check({tag, "_done"},     done, 0);
    check({tag, "_err"},      err, 0);
  endtask

  initial begin
    #500_000;
    $display("FAIL watchdog: got no finish, want finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int base, n;
    reset        = 1'b1;
    start        = 1'b0;
    length       = '0;
    bus.rx_valid = 1'b0;
    bus.rx_data  = '0;
    for (int i = 0; i < 256; i++) rom[i] = 16'($urandom);
    tick(3);
    check_reset_outputs("reset");
    reset = 1'b0;
    tick(2);

    // Zero length: error, no bytes, no busy.
    base = accept_cnt;
    do_start(16'd0);
    check("len0_err", err, 1);
    check("len0_busy", busy, 0);
    tick(5);
    check("len0_busy_later", busy, 0);
    check("len0_no_tx", accept_cnt, base);

    rom[0] = 16'h1234;
    rom[1] = 16'hABCD;
    rom[2] = 16'h00FF;
    run_transfer(3, 1'b0, 1'b1);

    for (int t = 0; t < 6; t++) begin
      n = $urandom_range(1, 5);
      for (int i = 0; i < n; i++) rom[i] = 16'($urandom);
      run_transfer(n, 1'b0, t[0]);
    end

    for (int i = 0; i < 2; i++) rom[i] = 16'($urandom);
    run_transfer(2, 1'b1, 1'b0);

`ifdef IMAGE_SENDER_HANDSHAKE_EN
    // No 'L' ever echoed: timeout after about TIMEOUT_CYCLES.
    begin
      int cyc = 0;
      do_start(16'd1);
      while (!err && cyc < 300) begin
        tick(1);
        cyc++;
      end
      check("timeout_err", err, 1);
      check("timeout_busy", busy, 0);
      check("timeout_cycles", (cyc >= 95 && cyc <= 110) ? 1 : 0, 1);
      tick(3);
      check("timeout_no_done", done, 0);
    end
`endif

    // Reset while the high data byte is being offered.
    base = accept_cnt;
    for (int i = 0; i < 2; i++) rom[i] = 16'($urandom);
    push_expected(2);
    credit_mode = 1'b1;
    credits     = 3;
    do_start(16'd2);
`ifdef IMAGE_SENDER_HANDSHAKE_EN
    tick(3);
    send_rx(8'h4C);
    wait_bytes(base + 2);
    tick(2);
    send_rx(8'h41);
    send_rx(8'h3D);
`endif
    wait_bytes(base + 3);
    tick(2);
    check("dat_hi_offered", bus.tx_valid, 1);
    reset = 1'b1;
    tick(1);
    check_reset_outputs("midreset");
    reset       = 1'b0;
    credit_mode = 1'b0;
    exp_q.delete();
    tick(3);

    rom[0] = 16'h5AA5;
    run_transfer(1, 1'b0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
